// File: rtl/fwd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fwd_pkg
// Description : Shared types and helpers for the forward/hazard unit.
//               fwd_stage_t describes one tracked in-flight writeback stage.
//               reg_addr_width() derives the register address width.
// Revision    : 1.0 - initial release
// ============================================================================
package fwd_pkg;

  // Stage address field is sized for the widest supported register file.
  // Narrower configurations zero-extend into it.
  localparam int FWD_ADDR_W_MAX = 8;

  typedef struct packed {
    logic                      valid;
    logic [FWD_ADDR_W_MAX-1:0] waddr;
    logic                      is_load;
  } fwd_stage_t;

  // max(1, $clog2(reg_count))
  function automatic int reg_addr_width(input int reg_count);
    int w;
    w = $clog2(reg_count);
    return (w < 1) ? 1 : w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/forward_hazard_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : forward_hazard_unit_if
// Description : Issue/read/forward bundle for forward_hazard_unit.
//               master : issue stage (drives issue_*, read_*, flush, clk_en)
//               slave  : hazard unit (drives fwd_en, stall)
// Ports       : clk_en, issue_valid, issue_we, issue_is_load, issue_waddr,
//               read_addr, read_used, flush, fwd_en, stall
// Revision    : 1.0 - initial release
// ============================================================================
interface forward_hazard_unit_if #(
  parameter int READ_PORTS    = 2,
  parameter int FORWARD_DEPTH = 3,
  parameter int REG_AW        = 3
);
  logic                                       clk_en;
  logic                                       issue_valid;
  logic                                       issue_we;
  logic                                       issue_is_load;
  logic [REG_AW-1:0]                          issue_waddr;
  logic [READ_PORTS-1:0][REG_AW-1:0]          read_addr;
  logic [READ_PORTS-1:0]                      read_used;
  logic                                       flush;
  logic [READ_PORTS-1:0][FORWARD_DEPTH-1:0]   fwd_en;
  logic                                       stall;

  modport master (
    output clk_en, issue_valid, issue_we, issue_is_load, issue_waddr,
           read_addr, read_used, flush,
    input  fwd_en, stall
  );

  modport slave (
    input  clk_en, issue_valid, issue_we, issue_is_load, issue_waddr,
           read_addr, read_used, flush,
    output fwd_en, stall
  );
endinterface
`default_nettype wire

// File: rtl/fwd_youngest_match.sv
`default_nettype none
// ============================================================================
// Module      : fwd_youngest_match
// Description : Reduces a per-stage match vector to a one-hot select of the
//               lowest-index (youngest) match plus its binary index.
// Ports       : match_i  - per-stage match flags
//               onehot_o - one-hot youngest match (zero when none)
//               idx_o    - index of youngest match (zero when none)
//               any_o    - at least one stage matched
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_youngest_match #(
  parameter int DEPTH = 3,
  parameter int IDX_W = 2
) (
  input  logic [DEPTH-1:0] match_i,
  output logic [DEPTH-1:0] onehot_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  // Scan oldest to youngest so the youngest hit is the last one written.
  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (match_i[i]) begin
        onehot_o    = '0;
        onehot_o[i] = 1'b1;
        idx_o       = IDX_W'(i);
      end
    end
  end

  assign any_o = |match_i;

endmodule
`default_nettype wire

// File: rtl/forward_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : forward_hazard_unit
// Description : Tracks in-flight register writes over FORWARD_DEPTH writeback
//               stages and, per read port, selects the youngest matching
//               stage for forwarding. Stalls issue when that youngest match
//               is a load that is not yet forwardable.
// Ports       : clk   - clock
//               rst   - synchronous active-high reset
//               hz_if - forward_hazard_unit_if.slave bundle
// Revision    : 1.0 - initial release
// ============================================================================
module forward_hazard_unit
  import fwd_pkg::*;
#(
  parameter int FORWARD_DEPTH    = 3,
  parameter int REGISTER_COUNT   = 8,
  parameter int READ_PORTS       = 2,
  parameter int LOAD_READY_STAGE = 1,
  parameter int ZERO_REG         = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  forward_hazard_unit_if.slave hz_if
);

  localparam int c_REG_AW = reg_addr_width(REGISTER_COUNT);
  localparam int c_IDX_W  = (FORWARD_DEPTH > 1) ? $clog2(FORWARD_DEPTH) : 1;

  if (LOAD_READY_STAGE < 0 || LOAD_READY_STAGE >= FORWARD_DEPTH) begin : g_chk_lrs
    $error("forward_hazard_unit: LOAD_READY_STAGE must be in 0..FORWARD_DEPTH-1");
  end
  if (READ_PORTS < 1) begin : g_chk_ports
    $error("forward_hazard_unit: READ_PORTS must be >= 1");
  end
  if (REGISTER_COUNT < 2) begin : g_chk_regs
    $error("forward_hazard_unit: REGISTER_COUNT must be >= 2");
  end
  if (c_REG_AW > FWD_ADDR_W_MAX) begin : g_chk_aw
    $error("forward_hazard_unit: register address wider than stage field");
  end

  fwd_stage_t stage_q [FORWARD_DEPTH];
  fwd_stage_t stage_d [FORWARD_DEPTH];

  logic [FORWARD_DEPTH-1:0] w_load_vec;
  logic [READ_PORTS-1:0]    w_port_stall;
  logic                     w_stall;

  for (genvar i = 0; i < FORWARD_DEPTH; i++) begin : g_load_vec
    assign w_load_vec[i] = stage_q[i].valid & stage_q[i].is_load;
  end

  for (genvar p = 0; p < READ_PORTS; p++) begin : g_port
    logic [FORWARD_DEPTH-1:0] w_match;
    logic [FORWARD_DEPTH-1:0] w_onehot;
    logic [c_IDX_W-1:0]       w_idx;
    logic                     w_any;
    logic                     w_zero_hit;

    assign w_zero_hit = (ZERO_REG == 1) && (hz_if.read_addr[p] == '0);

    for (genvar i = 0; i < FORWARD_DEPTH; i++) begin : g_stage
      assign w_match[i] = stage_q[i].valid
                        && (stage_q[i].waddr == FWD_ADDR_W_MAX'(hz_if.read_addr[p]))
                        && hz_if.read_used[p]
                        && !w_zero_hit;
    end

    fwd_youngest_match #(
      .DEPTH (FORWARD_DEPTH),
      .IDX_W (c_IDX_W)
    ) u_youngest (
      .match_i  (w_match),
      .onehot_o (w_onehot),
      .idx_o    (w_idx),
      .any_o    (w_any)
    );

    // Only the youngest match matters: an older ready copy is stale.
    assign w_port_stall[p] = w_any
                           && (|(w_onehot & w_load_vec))
                           && (int'(w_idx) < LOAD_READY_STAGE);

    assign hz_if.fwd_en[p] = w_stall ? '0 : w_onehot;
  end

  assign w_stall     = |w_port_stall;
  assign hz_if.stall = w_stall;

  // Stall turns the issuing slot into a bubble while older stages advance.
  always_comb begin
    for (int i = 0; i < FORWARD_DEPTH; i++) begin
      stage_d[i] = stage_q[i];
    end
    if (hz_if.clk_en) begin
      for (int i = FORWARD_DEPTH - 1; i > 0; i--) begin
        stage_d[i] = stage_q[i-1];
      end
      stage_d[0].valid   = hz_if.issue_valid & hz_if.issue_we & ~w_stall;
      stage_d[0].waddr   = FWD_ADDR_W_MAX'(hz_if.issue_waddr);
      stage_d[0].is_load = hz_if.issue_is_load;
      if (hz_if.flush) begin
        for (int i = 0; i < FORWARD_DEPTH; i++) begin
          stage_d[i].valid = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FORWARD_DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < FORWARD_DEPTH; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_forward_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_forward_hazard_unit
// Description : Scoreboard bench for forward_hazard_unit (default params).
//               Driver applies one directed vector per cycle and queues the
//               expected fwd_en/stall; a monitor compares on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_forward_hazard_unit;
  import fwd_pkg::*;

  localparam int c_AW = reg_addr_width(8);

  logic clk;
  logic rst;

  forward_hazard_unit_if #(
    .READ_PORTS    (2),
    .FORWARD_DEPTH (3),
    .REG_AW        (c_AW)
  ) hz_if ();

  forward_hazard_unit #(
    .FORWARD_DEPTH    (3),
    .REGISTER_COUNT   (8),
    .READ_PORTS       (2),
    .LOAD_READY_STAGE (1),
    .ZERO_REG         (1)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .hz_if (hz_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string          name;
    logic [1:0][2:0] fwd;
    logic           stall;
  } exp_t;

  exp_t sb [$];
  int   checks = 0;
  int   errors = 0;

  // Monitor: outputs are combinational and always presented, so one entry
  // is consumed per cycle once the driver has queued it.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (hz_if.fwd_en !== e.fwd || hz_if.stall !== e.stall) begin
        errors++;
        $display("FAIL %s: got fwd_en=%b stall=%b, expected fwd_en=%b stall=%b",
                 e.name, hz_if.fwd_en, hz_if.stall, e.fwd, e.stall);
      end
    end
  end

  task automatic step(input string nm,
                      input logic ce, input logic fl,
                      input logic iv, input logic we, input logic ld,
                      input logic [c_AW-1:0] wa,
                      input logic [c_AW-1:0] ra0, input logic ru0,
                      input logic [c_AW-1:0] ra1, input logic ru1,
                      input logic [2:0] e1, input logic [2:0] e0,
                      input logic es);
    exp_t e;
    hz_if.clk_en        = ce;
    hz_if.flush         = fl;
    hz_if.issue_valid   = iv;
    hz_if.issue_we      = we;
    hz_if.issue_is_load = ld;
    hz_if.issue_waddr   = wa;
    hz_if.read_addr[0]  = ra0;
    hz_if.read_used[0]  = ru0;
    hz_if.read_addr[1]  = ra1;
    hz_if.read_used[1]  = ru1;
    e.name   = nm;
    e.fwd[1] = e1;
    e.fwd[0] = e0;
    e.stall  = es;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst                 = 1'b1;
    hz_if.clk_en        = 1'($urandom);
    hz_if.flush         = 1'($urandom);
    hz_if.issue_valid   = 1'($urandom);
    hz_if.issue_we      = 1'($urandom);
    hz_if.issue_is_load = 1'($urandom);
    hz_if.issue_waddr   = c_AW'($urandom);
    hz_if.read_addr     = '0;
    hz_if.read_used     = '0;
    @(posedge clk);
    #1;
    // Second reset cycle: state already cleared by the first edge.
    step("rst_hold", 1, 0, 1, 1, 0, 3, 3, 1, 3, 1, 3'b000, 3'b000, 0);
    rst = 1'b0;

    // name          ce fl iv we ld wa ra0 ru0 ra1 ru1 e1      e0      st
    step("rst_rel",   1, 0, 0, 0, 0, 0, 3, 1, 3, 1, 3'b000, 3'b000, 0);
    // ALU write r3 walks through all stages then ages out.
    step("a_own",     1, 0, 1, 1, 0, 3, 3, 1, 0, 0, 3'b000, 3'b000, 0);
    step("a_s0",      1, 0, 0, 0, 0, 0, 3, 1, 0, 0, 3'b000, 3'b001, 0);
    step("a_s1",      1, 0, 0, 0, 0, 0, 3, 1, 0, 0, 3'b000, 3'b010, 0);
    step("a_s2",      1, 0, 0, 0, 0, 0, 3, 1, 0, 0, 3'b000, 3'b100, 0);
    step("a_gone",    1, 0, 0, 0, 0, 0, 3, 1, 0, 0, 3'b000, 3'b000, 0);
    // Back-to-back writes to r5: youngest wins.
    step("b_iss1",    1, 0, 1, 1, 0, 5, 5, 1, 0, 0, 3'b000, 3'b000, 0);
    step("b_iss2",    1, 0, 1, 1, 0, 5, 5, 1, 0, 0, 3'b000, 3'b001, 0);
    step("b_young",   1, 0, 0, 0, 0, 0, 5, 1, 0, 0, 3'b000, 3'b001, 0);
    step("b_s1",      1, 0, 0, 0, 0, 0, 5, 1, 0, 0, 3'b000, 3'b010, 0);
    step("b_s2",      1, 0, 0, 0, 0, 0, 5, 1, 0, 0, 3'b000, 3'b100, 0);
    // Load r2 then use on port1; r7 issued during stall becomes a bubble.
    step("c_iss",     1, 0, 1, 1, 1, 2, 0, 0, 2, 1, 3'b000, 3'b000, 0);
    step("c_stall",   1, 0, 1, 1, 0, 7, 7, 1, 2, 1, 3'b000, 3'b000, 1);
    step("c_ready",   1, 0, 0, 0, 0, 0, 7, 1, 2, 1, 3'b010, 3'b000, 0);
    step("c_s2",      1, 0, 0, 0, 0, 0, 0, 0, 2, 1, 3'b100, 3'b000, 0);
    // Load r6 hit on port0 stalls too.
    step("c2_iss",    1, 0, 1, 1, 1, 6, 0, 0, 0, 0, 3'b000, 3'b000, 0);
    step("c2_stall",  1, 0, 0, 0, 0, 0, 6, 1, 3, 1, 3'b000, 3'b000, 1);
    step("c2_drain1", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000, 0);
    step("c2_drain2", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000, 0);
    // r0 never matches; unused port never matches.
    step("d_w0",      1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000, 0);
    step("d_r0",      1, 0, 1, 1, 0, 6, 0, 1, 0, 0, 3'b000, 3'b000, 0);
    step("d_unused",  1, 0, 0, 0, 0, 0, 6, 0, 6, 1, 3'b001, 3'b000, 0);
    step("d_drain1",  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000, 0);
    step("d_drain2",  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000, 0);
    // Flush kills r4 and has priority over the r1 issued with it.
    step("e_w4",      1, 0, 1, 1, 0, 4, 0, 0, 0, 0, 3'b000, 3'b000, 0);
    step("e_flush",   1, 1, 1, 1, 0, 1, 4, 1, 0, 0, 3'b000, 3'b001, 0);
    step("e_after",   1, 0, 0, 0, 0, 0, 4, 1, 1, 1, 3'b000, 3'b000, 0);
    // clk_en low holds r4 at stage 0 and blocks the r5 issue.
    step("e_w4b",     1, 0, 1, 1, 0, 4, 0, 0, 0, 0, 3'b000, 3'b000, 0);
    step("e_hold1",   0, 0, 1, 1, 0, 5, 4, 1, 5, 1, 3'b000, 3'b001, 0);
    step("e_hold2",   0, 0, 1, 1, 0, 5, 4, 1, 5, 1, 3'b000, 3'b001, 0);
    step("e_hold3",   0, 0, 1, 1, 0, 5, 4, 1, 5, 1, 3'b000, 3'b001, 0);
    step("e_resume",  1, 0, 0, 0, 0, 0, 4, 1, 5, 1, 3'b000, 3'b001, 0);
    step("e_shift",   1, 0, 0, 0, 0, 0, 4, 1, 5, 1, 3'b000, 3'b010, 0);
    // Reset asserted while stalled drops stall next cycle.
    step("f_load",    1, 0, 1, 1, 1, 2, 4, 1, 0, 0, 3'b000, 3'b100, 0);
    rst = 1'b1;
    step("f_stall",   1, 0, 0, 0, 0, 0, 0, 0, 2, 1, 3'b000, 3'b000, 1);
    rst = 1'b0;
    step("f_post",    1, 0, 0, 0, 0, 0, 0, 0, 2, 1, 3'b000, 3'b000, 0);

    begin
      int budget;
      budget = 20;
      while (sb.size() > 0 && budget > 0) begin
        @(posedge clk);
        budget--;
      end
      if (sb.size() > 0) begin
        errors++;
        $display("FAIL drain: %0d expected entries left, required 0", sb.size());
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/forward_hazard_unit.md
FORWARD_HAZARD_UNIT -- requirements
Module: forward_hazard_unit

Interface
REQ-001 Parameter FORWARD_DEPTH, default 3: number of tracked downstream writeback stages, stage 0 youngest.
REQ-002 Parameter REGISTER_COUNT, default 8: architectural registers; RegAddrWidth = max(1, $clog2(REGISTER_COUNT)).
REQ-003 Parameter READ_PORTS, default 2: number of source operands checked per issued instruction.
REQ-004 Parameter LOAD_READY_STAGE, default 1: lowest stage index at which a load result is forwardable; legal range 0..FORWARD_DEPTH-1.
REQ-005 Parameter ZERO_REG, default 1: when 1, register 0 is hardwired and never matches.
REQ-006 clk  input  1  single clock; all state updates on posedge.
REQ-007 rst  input  1  synchronous reset, active-high.
REQ-008 clk_en  input  1  pipeline advance enable.
REQ-009 issue_valid, issue_we, issue_is_load  input  1 each  instruction in issue is valid / writes a register / is a load.
REQ-010 issue_waddr  input  RegAddrWidth  destination register of the issuing instruction.
REQ-011 read_addr  input  READ_PORTS x RegAddrWidth  source register per port.
REQ-012 read_used  input  READ_PORTS  port p is actually read.
REQ-013 flush  input  1  kill all tracked in-flight writes.
REQ-014 fwd_en  output  READ_PORTS x FORWARD_DEPTH  per-port one-hot forward select.
REQ-015 stall  output  1  hold issue one cycle; load result not yet forwardable.

Function
REQ-016 Each stage holds {valid, waddr, is_load}; on posedge with clk_en=1, stage i <= stage i-1 for i>0.
REQ-017 Stage 0 loads {issue_valid & issue_we & ~stall, issue_waddr, issue_is_load}; stall=1 therefore inserts a bubble while older stages still advance.
REQ-018 flush=1 with clk_en=1 clears every valid bit and has priority over the stage-0 load.
REQ-019 clk_en=0: all stage state holds; outputs remain combinationally derived from held state and current inputs.
REQ-020 Stage i matches port p iff valid, waddr==read_addr[p], read_used[p], and not (ZERO_REG==1 and read_addr[p]==0).
REQ-021 fwd_en[p] is one-hot at the lowest-index (youngest) matching stage; all-zero when no stage matches.
REQ-022 stall=1 iff for any port the youngest match has is_load=1 and index < LOAD_READY_STAGE.
REQ-023 While stall=1, fwd_en is forced all-zero on every port.
REQ-024 fwd_en and stall are combinational, zero latency; an issued write becomes visible to comparisons the cycle after issue.
REQ-025 An instruction never matches its own destination (not yet tracked); writes older than stage FORWARD_DEPTH-1 are not forwarded.
REQ-026 stall depends only on stage state, read_addr and read_used; no combinational path from issue_* to any output.

Reset
REQ-027 rst=1 on posedge clears all valid, waddr and is_load bits regardless of clk_en or flush.
REQ-028 During and after reset until a new issue: fwd_en=0, stall=0; reset mid-stall drops stall on the next cycle.

Structure
REQ-029 Package fwd_pkg holds typedef fwd_stage_t {valid, waddr, is_load} and the RegAddrWidth derivation function.
REQ-030 Sub-module fwd_youngest_match (match vector to one-hot youngest plus index) is instantiated once per read port.
REQ-031 Elaboration assertions enforce LOAD_READY_STAGE < FORWARD_DEPTH, READ_PORTS >= 1, REGISTER_COUNT >= 2.

Verification (defaults)
REQ-032 Random inputs, rst high 2 cycles -> fwd_en=0, stall=0 on the first cycle after reset release.
REQ-033 Issue ALU write r3, then read port0 r3 with no further writes -> fwd_en[0]=001, 010, 100, then 000 on successive cycles.
REQ-034 Issue ALU write r5 on two consecutive cycles, read r5 -> fwd_en[0]=001, not 011.
REQ-035 Issue load r2, next cycle read port1 r2 -> stall=1 and fwd_en=0 for one cycle; next cycle stall=0, fwd_en[1]=010.
REQ-036 Write r0 then read r0 -> fwd_en=0; write r6 then read r6 with read_used=0 -> fwd_en=0.
REQ-037 Write r4, flush -> following cycle read r4 gives fwd_en=0; write r4 with clk_en held low 3 cycles -> fwd_en[0]=001 throughout.
